// File: rtl/n101_spi_phy_ctrl.sv
// n101 SPI master PHY sequencer.
// Accepts one byte operation at a time, generates SCK from a programmable
// divider and shifts the byte out/in over 1, 2 or 4 data lines while driving
// an active-low chip select. A frame is SETUP -> SHIFT -> HOLD, each phase
// built from SCK half-periods of (sckdiv+1) core cycles.
module n101_spi_phy_ctrl #(
    parameter int DIV_W = 12,
    parameter int CS_N  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] io_sckdiv,
    input  logic             io_cpol,
    input  logic             io_cpha,
    input  logic             io_op_valid,
    output logic             io_op_ready,
    input  logic [7:0]       io_op_bits_data,
    input  logic [1:0]       io_op_bits_proto,
    input  logic             io_op_bits_dir,
    input  logic             io_op_bits_endian,
    input  logic [1:0]       io_op_bits_csid,
    input  logic             io_op_bits_cshold,
    output logic             io_rx_valid,
    output logic [7:0]       io_rx_bits,
    output logic             io_spi_sck,
    output logic             io_spi_dq_0_o,
    output logic             io_spi_dq_0_oe,
    input  logic             io_spi_dq_0_i,
    output logic             io_spi_dq_1_o,
    output logic             io_spi_dq_1_oe,
    input  logic             io_spi_dq_1_i,
    output logic             io_spi_dq_2_o,
    output logic             io_spi_dq_2_oe,
    input  logic             io_spi_dq_2_i,
    output logic             io_spi_dq_3_o,
    output logic             io_spi_dq_3_oe,
    input  logic             io_spi_dq_3_i,
    output logic             io_spi_cs_0,
    output logic             io_spi_cs_1,
    output logic             io_spi_cs_2,
    output logic             io_spi_cs_3
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t state_q, state_d;

    // Frame parameters captured at accept
    logic [DIV_W-1:0] div_q;
    logic             cpha_q;
    logic             dir_q;
    logic             endian_q;
    logic             cshold_q;
    logic [1:0]       proto_q;

    // Shift registers (LSB-first frames are bit-reversed at the edges so the
    // core always works MSB-first)
    logic [7:0] tx_q;
    logic [7:0] rx_sr_q;

    // Control registers
    logic [DIV_W-1:0] dcnt_q;
    logic [3:0]       ecnt_q;
    logic             sck_q;
    logic [CS_N-1:0]  cs_q;
    logic             rx_valid_q;
    logic [7:0]       rx_bits_q;

    logic       accept;
    logic       phase_end;
    logic       last_edge;
    logic [3:0] ecnt_m1;
    logic       edge_first;
    logic       edge_mid;
    logic       lead_ev;
    logic       trail_ev;
    logic       sample_ev;
    logic       shift_ev;

    logic [3:0] beat;
    logic [3:0] oe_pat;
    logic [7:0] tx_shifted;
    logic [7:0] rx_next;
    logic [3:0] dq_i;

    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Index of the last SCK half-period: 2*beats-1
    function automatic logic [3:0] last_edge_idx(input logic [1:0] p);
        case (p)
            2'd1:    return 4'd7;
            2'd2:    return 4'd3;
            default: return 4'd15;
        endcase
    endfunction

    assign accept    = io_op_valid && io_op_ready;
    assign phase_end = (dcnt_q == '0);
    assign last_edge = (ecnt_q == 4'd0);
    assign ecnt_m1   = ecnt_q - 4'd1;
    assign dq_i      = {io_spi_dq_3_i, io_spi_dq_2_i, io_spi_dq_1_i, io_spi_dq_0_i};

    // Leading edge opens SHIFT; every later half-period boundary is another
    // edge. The remaining-edge count is odd on leading edges, even on trailing.
    assign edge_first = (state_q == SETUP) && phase_end;
    assign edge_mid   = (state_q == SHIFT) && phase_end && !last_edge;
    assign lead_ev    = edge_first || (edge_mid && ecnt_m1[0]);
    assign trail_ev   = edge_mid && !ecnt_m1[0];
    assign sample_ev  = cpha_q ? trail_ev : lead_ev;
    // cpha=1: the opening leading edge re-presents beat 0, so only later
    // leading edges advance. cpha=0: the final trailing edge has no next beat.
    assign shift_ev   = cpha_q ? (edge_mid && ecnt_m1[0])
                               : (trail_ev && (ecnt_m1 != 4'd0));

    // Per-mode beat selection, output enables and shift/sample updates
    always_comb begin
        beat       = 4'd0;
        oe_pat     = 4'd0;
        tx_shifted = tx_q;
        rx_next    = rx_sr_q;
        case (proto_q)
            2'd1: begin
                beat       = {2'b00, tx_q[7:6]};
                oe_pat     = {2'b00, dir_q, dir_q};
                tx_shifted = {tx_q[5:0], 2'b00};
                rx_next    = {rx_sr_q[5:0], dq_i[1:0]};
            end
            2'd2: begin
                beat       = tx_q[7:4];
                oe_pat     = {4{dir_q}};
                tx_shifted = {tx_q[3:0], 4'b0000};
                rx_next    = {rx_sr_q[3:0], dq_i};
            end
            default: begin
                beat       = {3'b000, tx_q[7]};
                oe_pat     = 4'b0001;
                tx_shifted = {tx_q[6:0], 1'b0};
                rx_next    = {rx_sr_q[6:0], dq_i[1]};
            end
        endcase
    end

    // Next-state: each phase ends when the divider reaches zero
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (phase_end) state_d = SHIFT;
            SHIFT:   if (phase_end && last_edge) state_d = HOLD;
            HOLD:    if (phase_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Divider, edge counter, SCK, chip selects and received-byte strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dcnt_q     <= '0;
            ecnt_q     <= 4'd0;
            sck_q      <= 1'b0;
            cs_q       <= '1;
            rx_valid_q <= 1'b0;
            rx_bits_q  <= 8'd0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                dcnt_q <= io_sckdiv;
                sck_q  <= io_cpol;
                cs_q   <= ~({{(CS_N-1){1'b0}}, 1'b1} << io_op_bits_csid);
            end else if (state_q != IDLE) begin
                dcnt_q <= phase_end ? div_q : dcnt_q - 1'b1;
            end
            if (edge_first) begin
                ecnt_q <= last_edge_idx(proto_q);
                sck_q  <= ~sck_q;
            end else if (edge_mid) begin
                ecnt_q <= ecnt_m1;
                sck_q  <= ~sck_q;
            end
            if ((state_q == HOLD) && phase_end) begin
                rx_valid_q <= 1'b1;
                rx_bits_q  <= endian_q ? bit_rev(rx_sr_q) : rx_sr_q;
                if (!cshold_q) cs_q <= '1;
            end
        end
    end

    // Frame capture and data shifting
    always_ff @(posedge clock) begin
        if (accept) begin
            div_q    <= io_sckdiv;
            cpha_q   <= io_cpha;
            dir_q    <= io_op_bits_dir;
            endian_q <= io_op_bits_endian;
            cshold_q <= io_op_bits_cshold;
            proto_q  <= io_op_bits_proto;
            tx_q     <= io_op_bits_endian ? bit_rev(io_op_bits_data) : io_op_bits_data;
        end else begin
            if (shift_ev)  tx_q    <= tx_shifted;
            if (sample_ev) rx_sr_q <= rx_next;
        end
    end

    assign io_op_ready = (state_q == IDLE);
    assign io_rx_valid = rx_valid_q;
    assign io_rx_bits  = rx_bits_q;
    assign io_spi_sck  = (state_q == IDLE) ? io_cpol : sck_q;

    assign {io_spi_dq_3_o, io_spi_dq_2_o, io_spi_dq_1_o, io_spi_dq_0_o} =
        (state_q == IDLE) ? 4'd0 : beat;
    assign {io_spi_dq_3_oe, io_spi_dq_2_oe, io_spi_dq_1_oe, io_spi_dq_0_oe} =
        (state_q == IDLE) ? 4'd0 : oe_pat;

    assign io_spi_cs_0 = cs_q[0];
    assign io_spi_cs_1 = cs_q[1];
    assign io_spi_cs_2 = cs_q[2];
    assign io_spi_cs_3 = cs_q[3];

endmodule

// File: tb/tb_n101_spi_phy_ctrl.sv
// Testbench for n101_spi_phy_ctrl: scenario tasks plus an rx scoreboard.
module tb_n101_spi_phy_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] io_sckdiv = 12'd0;
    logic        io_cpol = 1'b0;
    logic        io_cpha = 1'b0;
    logic        io_op_valid = 1'b0;
    logic        io_op_ready;
    logic [7:0]  io_op_bits_data = 8'd0;
    logic [1:0]  io_op_bits_proto = 2'd0;
    logic        io_op_bits_dir = 1'b0;
    logic        io_op_bits_endian = 1'b0;
    logic [1:0]  io_op_bits_csid = 2'd0;
    logic        io_op_bits_cshold = 1'b0;
    logic        io_rx_valid;
    logic [7:0]  io_rx_bits;
    logic        io_spi_sck;
    logic        dq0_o, dq0_oe, dq0_i;
    logic        dq1_o, dq1_oe, dq1_i;
    logic        dq2_o, dq2_oe, dq2_i;
    logic        dq3_o, dq3_oe, dq3_i;
    logic        cs0, cs1, cs2, cs3;

    logic [3:0]  dq_drv = 4'd0;
    logic        loop_en = 1'b0;
    logic [3:0]  o_v, oe_v, cs_v;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mask_q[$];
    logic [7:0]  mon_exp, mon_mask;

    assign dq0_i = dq_drv[0];
    assign dq1_i = loop_en ? dq0_o : dq_drv[1];
    assign dq2_i = dq_drv[2];
    assign dq3_i = dq_drv[3];
    assign o_v   = {dq3_o, dq2_o, dq1_o, dq0_o};
    assign oe_v  = {dq3_oe, dq2_oe, dq1_oe, dq0_oe};
    assign cs_v  = {cs3, cs2, cs1, cs0};

    always #5 clock = ~clock;

    n101_spi_phy_ctrl dut (
        .clock(clock), .reset(reset), .io_sckdiv(io_sckdiv),
        .io_cpol(io_cpol), .io_cpha(io_cpha),
        .io_op_valid(io_op_valid), .io_op_ready(io_op_ready),
        .io_op_bits_data(io_op_bits_data), .io_op_bits_proto(io_op_bits_proto),
        .io_op_bits_dir(io_op_bits_dir), .io_op_bits_endian(io_op_bits_endian),
        .io_op_bits_csid(io_op_bits_csid), .io_op_bits_cshold(io_op_bits_cshold),
        .io_rx_valid(io_rx_valid), .io_rx_bits(io_rx_bits),
        .io_spi_sck(io_spi_sck),
        .io_spi_dq_0_o(dq0_o), .io_spi_dq_0_oe(dq0_oe), .io_spi_dq_0_i(dq0_i),
        .io_spi_dq_1_o(dq1_o), .io_spi_dq_1_oe(dq1_oe), .io_spi_dq_1_i(dq1_i),
        .io_spi_dq_2_o(dq2_o), .io_spi_dq_2_oe(dq2_oe), .io_spi_dq_2_i(dq2_i),
        .io_spi_dq_3_o(dq3_o), .io_spi_dq_3_oe(dq3_oe), .io_spi_dq_3_i(dq3_i),
        .io_spi_cs_0(cs0), .io_spi_cs_1(cs1), .io_spi_cs_2(cs2), .io_spi_cs_3(cs3)
    );

    // Scoreboard: every received byte must match the oldest expectation
    always @(negedge clock) begin
        if (io_rx_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected got=%h exp=none", io_rx_bits);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_mask = mask_q.pop_front();
                if ((io_rx_bits & mon_mask) !== (mon_exp & mon_mask)) begin
                    n_fail++;
                    $display("FAIL rx_data got=%h exp=%h mask=%h", io_rx_bits, mon_exp, mon_mask);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Drive one op; call at a negedge with the DUT idle. Returns just after accept.
    task automatic start_op(input logic [7:0] d, input logic [1:0] p, input logic dr,
                            input logic en, input logic [1:0] id, input logic hold,
                            input logic [11:0] dv, input logic pol, input logic pha);
        io_op_bits_data   = d;
        io_op_bits_proto  = p;
        io_op_bits_dir    = dr;
        io_op_bits_endian = en;
        io_op_bits_csid   = id;
        io_op_bits_cshold = hold;
        io_sckdiv         = dv;
        io_cpol           = pol;
        io_cpha           = pha;
        io_op_valid       = 1'b1;
        @(posedge clock);
        #1;
        io_op_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        n_checks++;
        if (io_op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", io_op_ready); end
        n_checks++;
        if (io_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", io_rx_valid); end
        n_checks++;
        if (cs_v !== 4'hF) begin n_fail++; $display("FAIL reset_cs got=%h exp=f", cs_v); end
        n_checks++;
        if ({o_v, oe_v} !== 8'h00) begin n_fail++; $display("FAIL reset_dq got=%h exp=00", {o_v, oe_v}); end
        n_checks++;
        if (io_spi_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck got=%b exp=0", io_spi_sck); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_basic;
        logic [7:0] bits = 8'd0;
        int nb = 0;
        loop_en = 1'b1;
        exp_q.push_back(8'hA5); mask_q.push_back(8'hFF);
        start_op(8'hA5, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clock);
            n_checks++;
            if (cs0 !== (c <= 18 ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL single_cs0 cycle=%0d got=%b exp=%b", c, cs0, (c <= 18 ? 1'b0 : 1'b1));
            end
            n_checks++;
            if (io_rx_valid !== (c == 19)) begin
                n_fail++; $display("FAIL single_rx_valid cycle=%0d got=%b exp=%b", c, io_rx_valid, (c == 19));
            end
            if (io_spi_sck === 1'b1) begin bits = {bits[6:0], dq0_o}; nb++; end
        end
        n_checks++;
        if (nb !== 8 || bits !== 8'hA5) begin
            n_fail++; $display("FAIL single_dq0_bits got=%h/%0d exp=a5/8", bits, nb);
        end
        n_checks++;
        if (io_op_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", io_op_ready); end
    endtask

    task automatic test_quad_tx;
        logic [3:0] nib[2];
        int rises = 0;
        logic prev;
        logic oe_bad = 1'b0;
        loop_en = 1'b0;
        dq_drv  = 4'h0;
        exp_q.push_back(8'h00); mask_q.push_back(8'h00);
        start_op(8'h3C, 2'd2, 1'b1, 1'b0, 2'd1, 1'b0, 12'd1, 1'b0, 1'b0);
        prev = io_spi_sck;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clock);
            if (io_spi_sck && !prev) begin
                if (rises < 2) nib[rises] = o_v;
                rises++;
            end
            prev = io_spi_sck;
            if (c <= 12 && oe_v !== 4'hF) oe_bad = 1'b1;
            if (c == 12) begin
                n_checks++;
                if (cs1 !== 1'b0) begin n_fail++; $display("FAIL quad_tx_cs1 got=%b exp=0", cs1); end
            end
        end
        n_checks++;
        if (rises !== 2) begin n_fail++; $display("FAIL quad_tx_pulses got=%0d exp=2", rises); end
        n_checks++;
        if (rises >= 2 && {nib[0], nib[1]} !== 8'h3C) begin
            n_fail++; $display("FAIL quad_tx_nibbles got=%h exp=3c", {nib[0], nib[1]});
        end
        n_checks++;
        if (oe_bad !== 1'b0) begin n_fail++; $display("FAIL quad_tx_oe_active got=notF exp=f"); end
        n_checks++;
        if (io_rx_valid !== 1'b1) begin n_fail++; $display("FAIL quad_tx_latency got=%b exp=1 at cycle 13", io_rx_valid); end
        n_checks++;
        if (oe_v !== 4'h0 || cs_v !== 4'hF) begin
            n_fail++; $display("FAIL quad_tx_after got=oe%h cs%h exp=oe0 csf", oe_v, cs_v);
        end
    endtask

    task automatic test_quad_rx;
        int rises = 0;
        logic prev;
        logic oe_bad = 1'b0;
        loop_en = 1'b0;
        dq_drv  = 4'h9;
        exp_q.push_back(8'h96); mask_q.push_back(8'hFF);
        start_op(8'hFF, 2'd2, 1'b0, 1'b0, 2'd3, 1'b0, 12'd1, 1'b0, 1'b0);
        prev = io_spi_sck;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clock);
            if (io_spi_sck && !prev) begin
                rises++;
                if (rises == 1) dq_drv = 4'h6;
            end
            prev = io_spi_sck;
            if (oe_v !== 4'h0) oe_bad = 1'b1;
        end
        n_checks++;
        if (oe_bad !== 1'b0) begin n_fail++; $display("FAIL quad_rx_oe got=nonzero exp=0"); end
        n_checks++;
        if (io_rx_valid !== 1'b1 || io_rx_bits !== 8'h96) begin
            n_fail++; $display("FAIL quad_rx_byte got=%b/%h exp=1/96", io_rx_valid, io_rx_bits);
        end
        dq_drv = 4'h0;
    endtask

    task automatic test_lsb_cpol1_cpha1;
        logic [7:0] bits = 8'd0;
        int nb = 0;
        logic prev;
        loop_en = 1'b1;
        io_cpol = 1'b1;
        @(negedge clock);
        n_checks++;
        if (io_spi_sck !== 1'b1) begin n_fail++; $display("FAIL cpol1_idle_sck got=%b exp=1", io_spi_sck); end
        exp_q.push_back(8'h01); mask_q.push_back(8'hFF);
        start_op(8'h01, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 12'd0, 1'b1, 1'b1);
        prev = io_spi_sck;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clock);
            if (c == 2) begin
                n_checks++;
                if (io_spi_sck !== 1'b0 || dq0_o !== 1'b1) begin
                    n_fail++; $display("FAIL cpha1_first_bit got=sck%b dq0%b exp=sck0 dq01", io_spi_sck, dq0_o);
                end
            end
            if (c <= 17 && io_spi_sck && !prev) begin bits = {bits[6:0], dq0_o}; nb++; end
            prev = io_spi_sck;
            if (c == 18) begin
                n_checks++;
                if (io_spi_sck !== 1'b1) begin n_fail++; $display("FAIL cpha1_hold_sck got=%b exp=1", io_spi_sck); end
            end
        end
        n_checks++;
        if (nb !== 8 || bits !== 8'h80) begin
            n_fail++; $display("FAIL cpha1_rising_bits got=%h/%0d exp=80/8", bits, nb);
        end
        n_checks++;
        if (io_rx_valid !== 1'b1) begin n_fail++; $display("FAIL cpha1_latency got=%b exp=1", io_rx_valid); end
        io_cpol = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic others_bad = 1'b0;
        logic cs2_bad = 1'b0;
        loop_en = 1'b1;
        exp_q.push_back(8'h11); mask_q.push_back(8'hFF);
        exp_q.push_back(8'h22); mask_q.push_back(8'hFF);
        start_op(8'h11, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1, 12'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clock);
            if (cs2 !== 1'b0) cs2_bad = 1'b1;
            if ({cs3, cs1, cs0} !== 3'b111) others_bad = 1'b1;
        end
        n_checks++;
        if (io_rx_valid !== 1'b1 || io_op_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first_done got=rxv%b rdy%b exp=1/1", io_rx_valid, io_op_ready);
        end
        start_op(8'h22, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 12'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clock);
            if (c <= 18 && cs2 !== 1'b0) cs2_bad = 1'b1;
            if ({cs3, cs1, cs0} !== 3'b111) others_bad = 1'b1;
        end
        n_checks++;
        if (cs2_bad !== 1'b0) begin n_fail++; $display("FAIL b2b_cs2_held got=deasserted exp=low"); end
        n_checks++;
        if (others_bad !== 1'b0) begin n_fail++; $display("FAIL b2b_other_cs got=low exp=high"); end
        n_checks++;
        if (io_rx_valid !== 1'b1 || cs2 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_done got=rxv%b cs2%b exp=1/1", io_rx_valid, cs2);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic rx_seen = 1'b0;
        int lat = 0;
        loop_en = 1'b1;
        start_op(8'hC3, 2'd1, 1'b1, 1'b0, 2'd1, 1'b1, 12'd1, 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (cs_v !== 4'hF || oe_v !== 4'h0 || io_op_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_outputs got=cs%h oe%h rdy%b exp=csf oe0 rdy1", cs_v, oe_v, io_op_ready);
        end
        repeat (3) begin
            @(negedge clock);
            if (io_rx_valid !== 1'b0) rx_seen = 1'b1;
        end
        reset = 1'b0;
        repeat (15) begin
            @(negedge clock);
            if (io_rx_valid !== 1'b0) rx_seen = 1'b1;
        end
        n_checks++;
        if (rx_seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_rx got=pulse exp=none"); end
        exp_q.push_back(8'h5A); mask_q.push_back(8'hFF);
        start_op(8'h5A, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 12'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clock);
            if (io_rx_valid === 1'b1) lat = c;
        end
        n_checks++;
        if (lat !== 19) begin n_fail++; $display("FAIL midreset_next_frame got=%0d exp=19", lat); end
    endtask

    initial begin
        test_reset();
        test_single_basic();
        test_quad_tx();
        test_quad_rx();
        test_lsb_cpol1_cpha1();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (3) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rx_missing got=%0d pending exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/n101_spi_phy_ctrl.md
Name: n101_spi_phy_ctrl

Overview:
- SPI master physical-layer sequencer for the n101 peripheral subsystem.
- Takes byte-wide operations from the SPI controller FIFO/flash-XIP arbiter and generates SCK.
- Shifts data in single, dual or quad mode, samples input data, and drives active-low chip selects.
- Outputs feed n101_spigpioport directly: the io_spi_* bundle, one per-bit dq o/oe/i triple and four cs lines.

Parameters:
- DIV_W, 12, width of SCK divider field.
- CS_N, 4, number of chip selects; fixed at 4 to match the pin port.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous active-high reset
- io_sckdiv  in  DIV_W  SCK half-period = io_sckdiv+1 clock cycles
- io_cpol  in  1  SCK idle level
- io_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- io_op_valid  in  1  operation request
- io_op_ready  out  1  sequencer can accept an operation
- io_op_bits_data  in  8  transmit byte
- io_op_bits_proto  in  2  0 single, 1 dual, 2 quad; 3 is treated as single
- io_op_bits_dir  in  1  dual/quad only: 1 = drive dq, 0 = receive
- io_op_bits_endian  in  1  0 MSB-first, 1 LSB-first
- io_op_bits_csid  in  2  chip select index
- io_op_bits_cshold  in  1  keep CS asserted after this frame
- io_rx_valid  out  1  one-cycle pulse carrying the received byte
- io_rx_bits  out  8  received byte
- io_spi_sck  out  1  to port
- io_spi_dq_0_o / io_spi_dq_0_oe / io_spi_dq_0_i  out/out/in  1 each
- Same o/oe/i triple for dq_1, dq_2 and dq_3.
- io_spi_cs_0..io_spi_cs_3  out  1 each  active-low

Behaviour:
- Reset values: state IDLE; io_op_ready=1; io_rx_valid=0; io_rx_bits=0; all dq_o=0; all dq_oe=0; all cs=1; internal sck register=0.
- io_spi_sck = io_cpol while in IDLE, otherwise the internal sck register.
- Beats per byte: single 8, dual 4, quad 2. Bits per beat: 1, 2, 4 respectively.
- Accept rule: io_op_valid & io_op_ready in cycle 0.
  - data, proto, dir, endian and csid are latched; cpol, cpha and sckdiv are also latched at accept.
  - Later changes to any of these have no effect on the frame in flight.
- State SETUP (entered cycle 1):
  - cs[csid] driven 0; first beat placed on dq_o.
  - dq_oe: single mode → dq0=1 and dq1..3=0; dual/quad → the used lines = dir, unused lines = 0.
  - Lasts sckdiv+1 cycles, then SHIFT.
- State SHIFT:
  - SCK toggles every sckdiv+1 cycles for 2×beats half-periods, ending at the cpol level.
  - Sample edge = leading edge if cpha=0, trailing edge if cpha=1; the other edge is the shift edge.
  - With cpha=1 the first leading edge is a shift edge that presents beat 0 again (no advance); data advances on each subsequent shift edge.
  - Sampling sources: single mode samples dq1_i; dual samples dq1..0_i; quad samples dq3..0_i.
  - Bit mapping for MSB-first: bit 7 is transmitted first, and within a beat the higher bit goes on the higher dq index. LSB-first mirrors this.
- State HOLD: sckdiv+1 cycles with SCK at cpol, then return to IDLE.
- IDLE re-entry:
  - io_rx_valid=1 for one cycle with the assembled byte; io_op_ready=1 in the same cycle.
  - All dq_oe=0.
  - If cshold=0, all cs go to 1. If cshold=1, cs[csid] stays 0 until the end of the next frame that has cshold=0.
- A new op accepted while CS is held uses its own csid; if that csid differs, the previous CS goes to 1 in the same cycle the new one goes to 0.
- Latency: io_rx_valid at cycle 1+(sckdiv+1)×(2×beats+2). A back-to-back op can be accepted in that same cycle.
- io_rx_valid has no backpressure; in dual/quad with dir=1 the received value is whatever was sampled and is don't-care.
- Reset asserted mid-frame: outputs go to their reset values immediately (async); no io_rx_valid is produced; the first accept after release starts a fresh frame.
- Counters: the divider counter counts down from sckdiv to 0, the edge counter from 2×beats−1; neither wraps outside the active frame.

Test Plan:
- Single mode, cpol=0, cpha=0, sckdiv=0, data 0xA5, dq1_i looped from dq0_o → dq0 shows 1,0,1,0,0,1,0,1 at rising edges; io_spi_cs_0 low cycles 1–18; io_rx_valid with 0xA5 at cycle 19.
- Quad, dir=1, sckdiv=1, data 0x3C → dq[3:0]=0x3 then 0xC; all oe=1; 2 SCK pulses; io_rx_valid at cycle 13; oe all 0 afterwards.
- Quad, dir=0, bench drives dq_i=0x9 then 0x6 at sample edges → all oe=0; io_rx_bits=0x96.
- Single mode, cpol=1, cpha=1, LSB-first, data 0x01 → SCK idles 1; dq0=1 during the first bit; sampling occurs on rising (trailing) edges; received byte matches the looped value.
- Two back-to-back ops with csid=2, first cshold=1 then cshold=0 → io_spi_cs_2 low continuously across both frames and high after the second io_rx_valid; cs_0, cs_1 and cs_3 stay 1 throughout.
- Assert reset during SHIFT of a dual frame → all cs=1, oe=0, io_op_ready=1 immediately; no io_rx_valid; a subsequent 0x5A frame completes correctly.
